// File: rtl/instruction_fetch_stage.sv
// Instruction-fetch stage: PC, program memory with debug load port, HALT
// detection and enabled-cycle counter feeding the falling-edge IF/ID register.
module instruction_fetch_stage #(
  parameter int unsigned          NB_DATA   = 32,
  parameter int unsigned          NB_PC     = 7,
  parameter logic [NB_DATA-1:0]   HALT_WORD = NB_DATA'(32'hFFFF_FFFF),
  parameter logic [NB_DATA-1:0]   NOP_WORD  = NB_DATA'(32'h0000_0000)
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               en_pipeline,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [NB_PC-1:0]   target_i,
  input  logic               mem_we_i,
  input  logic [NB_PC-1:0]   mem_addr_i,
  input  logic [NB_DATA-1:0] mem_data_i,
  output logic [NB_PC-1:0]   pc_o,
  output logic [NB_DATA-1:0] instruction_o,
  output logic               halted_o,
  output logic [31:0]        cycles_o
);

  localparam int unsigned DEPTH  = 2 ** NB_PC;
  localparam int unsigned NB_CYC = 32;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [NB_PC-1:0]    r_pc;
  logic [NB_PC-1:0]    w_pc_next;
  logic [NB_PC-1:0]    w_pc_inc;
  logic [NB_CYC-1:0]   r_cycles;
  logic [NB_CYC-1:0]   w_cycles_next;
  logic [NB_DATA-1:0]  r_mem [DEPTH];
  logic [NB_DATA-1:0]  w_fetch;
  logic                w_is_halt;

  // Program memory: not reset, loadable at any time including during reset
  always_ff @(posedge clock_i) begin
    if (mem_we_i) begin
      r_mem[mem_addr_i] <= mem_data_i;
    end
  end

  assign w_fetch   = r_mem[r_pc];
  assign w_is_halt = (w_fetch == HALT_WORD);
  assign w_pc_inc  = r_pc + NB_PC'(1);

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state  <= ST_RUN;
      r_pc     <= '0;
      r_cycles <= '0;
    end else begin
      r_state  <= w_state_next;
      r_pc     <= w_pc_next;
      r_cycles <= w_cycles_next;
    end
  end

  // Redirect beats halt and stall so a wrong-path HALT gets squashed
  always_comb begin
    w_state_next  = r_state;
    w_pc_next     = r_pc;
    w_cycles_next = r_cycles;
    if (en_pipeline) begin
      if (r_state == ST_RUN) begin
        w_cycles_next = r_cycles + NB_CYC'(1);
      end
      if (redirect_i) begin
        w_pc_next    = target_i;
        w_state_next = ST_RUN;
      end else begin
        case (r_state)
          ST_RUN: begin
            if (!stall_i) begin
              if (w_is_halt) begin
                w_state_next = ST_HALT;
              end else begin
                w_pc_next = w_pc_inc;
              end
            end
          end
          ST_HALT: begin
            w_state_next = ST_HALT;
          end
          default: begin
            w_state_next = ST_RUN;
          end
        endcase
      end
    end
  end

  assign pc_o          = w_pc_inc;
  assign halted_o      = (r_state == ST_HALT);
  assign instruction_o = (r_state == ST_HALT) ? NOP_WORD : w_fetch;
  assign cycles_o      = r_cycles;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed program walk plus random stimulus
// checked every cycle against a word-level reference model.
module tb_instruction_fetch_stage;

  localparam int unsigned DEPTH = 128;
  localparam logic [31:0] HALTW = 32'hFFFF_FFFF;
  localparam logic [31:0] WA = 32'hA0A0_0001;
  localparam logic [31:0] WB = 32'hB0B0_0002;
  localparam logic [31:0] WC = 32'hC0C0_0003;
  localparam logic [31:0] WX = 32'hDEAD_0127;
  localparam logic [31:0] WY = 32'h5EED_0000;
  localparam logic [31:0] WZ = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        rst_v = 1'b0;
  logic        en_v = 1'b0;
  logic        st_v = 1'b0;
  logic        rd_v = 1'b0;
  logic [6:0]  tg_v = '0;
  logic        we_v = 1'b0;
  logic [6:0]  wa_v = '0;
  logic [31:0] wd_v = '0;
  logic [6:0]  pc_o;
  logic [31:0] instruction_o;
  logic        halted_o;
  logic [31:0] cycles_o;

  instruction_fetch_stage dut (
    .clock_i      (clk),
    .reset_i      (rst_v),
    .en_pipeline  (en_v),
    .stall_i      (st_v),
    .redirect_i   (rd_v),
    .target_i     (tg_v),
    .mem_we_i     (we_v),
    .mem_addr_i   (wa_v),
    .mem_data_i   (wd_v),
    .pc_o         (pc_o),
    .instruction_o(instruction_o),
    .halted_o     (halted_o),
    .cycles_o     (cycles_o)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_mem [DEPTH];
  int          m_pc = 0;
  bit          m_halt = 1'b0;
  int unsigned m_cyc = 0;

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;
  int lit_req = 0;
  int lit_done = 0;
  int          lit_pc;
  logic [31:0] lit_ins;
  bit          lit_h;
  int unsigned lit_c;

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Compare process: model every cycle, plus any pending literal expectation
  always @(negedge clk) begin
    if (chk_on) begin
      cmp("pc_o", 32'(pc_o), 32'((m_pc + 1) % DEPTH));
      cmp("instruction_o", instruction_o, m_halt ? 32'h0 : m_mem[m_pc]);
      cmp("halted_o", 32'(halted_o), 32'(m_halt));
      cmp("cycles_o", cycles_o, m_cyc);
    end
    if (lit_req != lit_done) begin
      lit_done = lit_req;
      cmp("lit_pc_o", 32'(pc_o), 32'(lit_pc));
      cmp("lit_instruction_o", instruction_o, lit_ins);
      cmp("lit_halted_o", 32'(halted_o), 32'(lit_h));
      cmp("lit_cycles_o", cycles_o, lit_c);
    end
  end

  task automatic lit(input int p, input logic [31:0] ins, input bit h, input int unsigned c);
    lit_pc  = p;
    lit_ins = ins;
    lit_h   = h;
    lit_c   = c;
    lit_req++;
  endtask

  task automatic model_reset();
    m_pc = 0;
    m_halt = 1'b0;
    m_cyc = 0;
  endtask

  // Apply inputs, clock one edge, advance the model from the pre-edge state
  task automatic drive(input bit rst, input bit en, input bit st, input bit rd,
                       input logic [6:0] tg, input bit we, input logic [6:0] wa,
                       input logic [31:0] wd);
    logic [31:0] cur;
    rst_v = rst; en_v = en; st_v = st; rd_v = rd; tg_v = tg;
    we_v = we; wa_v = wa; wd_v = wd;
    if (!rst) model_reset();
    @(posedge clk);
    cur = m_mem[m_pc];
    if (!rst) begin
      model_reset();
    end else if (en) begin
      if (!m_halt) m_cyc = m_cyc + 1;
      if (rd) begin
        m_pc = int'(tg);
        m_halt = 1'b0;
      end else if (!m_halt && !st) begin
        if (cur == HALTW) m_halt = 1'b1;
        else m_pc = (m_pc + 1) % DEPTH;
      end
    end
    if (we) m_mem[wa] = wd;
    #1;
  endtask

  task automatic run(input bit st = 1'b0);
    drive(1'b1, 1'b1, st, 1'b0, 7'd0, 1'b0, 7'd0, 32'h0);
  endtask

  initial begin
    logic [31:0] d;
    // Load the whole memory while held in reset
    for (int i = 0; i < DEPTH; i++) begin
      d = $urandom;
      if (d == HALTW) d = 32'h0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b1, 7'(i), d);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b1, 7'd0, WA);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b1, 7'd1, WB);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b1, 7'd2, WC);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b1, 7'd3, HALTW);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b1, 7'd127, WX);
    chk_on = 1'b1;
    lit(1, WA, 1'b0, 0);

    // Straight-line program to HALT
    run(); lit(2, WB, 1'b0, 1);
    run(); lit(3, WC, 1'b0, 2);
    run(); lit(4, HALTW, 1'b0, 3);
    run(); lit(4, 32'h0, 1'b1, 4);
    run(); lit(4, 32'h0, 1'b1, 4);
    // Redirect out of halt, then stall at pc=1
    drive(1'b1, 1'b1, 1'b0, 1'b1, 7'd1, 1'b0, 7'd0, 32'h0); lit(2, WB, 1'b0, 4);
    run(1'b1); lit(2, WB, 1'b0, 5);
    run(1'b1); lit(2, WB, 1'b0, 6);
    run(); lit(3, WC, 1'b0, 7);
    // Pipeline disabled for three edges
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 7'd0, 32'h0); lit(3, WC, 1'b0, 7);
    end
    run(); lit(4, HALTW, 1'b0, 8);
    // Redirect squashes the HALT at pc=3
    drive(1'b1, 1'b1, 1'b0, 1'b1, 7'd0, 1'b0, 7'd0, 32'h0); lit(1, WA, 1'b0, 9);
    // Wrap: redirect to 127 while loading mem[0]=Y
    drive(1'b1, 1'b1, 1'b0, 1'b1, 7'd127, 1'b1, 7'd0, WY); lit(0, WX, 1'b0, 10);
    run(); lit(1, WY, 1'b0, 11);
    run(); lit(2, WB, 1'b0, 12);
    run(); lit(3, WC, 1'b0, 13);
    // Write to the current pc under stall shows up next cycle
    drive(1'b1, 1'b1, 1'b1, 1'b0, 7'd0, 1'b1, 7'd2, WZ); lit(3, WZ, 1'b0, 14);
    // Asynchronous reset between edges
    rst_v = 1'b0;
    model_reset();
    lit(1, WY, 1'b0, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 7'd0, 32'h0); lit(1, WY, 1'b0, 0);
    run(); lit(2, WB, 1'b0, 1);

    // Randomized phase
    for (int n = 0; n < 3000; n++) begin
      bit rst, en, st, rd, we;
      rst = ($urandom_range(0, 199) != 0);
      en  = ($urandom_range(0, 99) < 85);
      st  = ($urandom_range(0, 99) < 20);
      rd  = ($urandom_range(0, 99) < 10);
      we  = ($urandom_range(0, 99) < 30);
      d   = ($urandom_range(0, 5) == 0) ? HALTW : $urandom;
      drive(rst, en, st, rd, 7'($urandom_range(0, DEPTH - 1)), we,
            7'($urandom_range(0, DEPTH - 1)), d);
    end
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
